fft_out_serializer: RTL and testbench
=====================================

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each real/imag sample.
REQ-002 Parameter FRAMES, fixed at 2: frame buffer depth (ping-pong); no other value is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  the parallel frame on x_in_* is valid this cycle.
REQ-006 in_ready  output  1  block can accept a frame this cycle.
REQ-007 x_in_k_real, x_in_k_imag (k=0..7)  input  WIDTH each, signed  FFT bin k of the frame, natural order, from the final FFT stage.
REQ-008 out_valid  output  1  out_real/out_imag hold a valid bin.
REQ-009 out_ready  input  1  downstream accepts the current bin.
REQ-010 out_real, out_imag  output  WIDTH each, signed  current bin value.
REQ-011 out_index  output  3  bin number (0..7) of the current bin.
REQ-012 out_last  output  1  high when out_index == 7 and out_valid is high.

Function
REQ-013 The block SHALL contain two frame buffers B0/B1, each holding 8 complex samples, plus registers wr_sel, rd_sel (1 bit each), count (0..2) and idx (3 bits).
REQ-014 Input transfer SHALL occur when in_valid && in_ready; all 16 inputs are written into B[wr_sel] at that edge and wr_sel toggles.
REQ-015 in_ready SHALL be high iff count < 2 and rst is low; it is a function of registered state only, so there is no bypass when a frame drains in the same cycle.
REQ-016 in_valid with in_ready low SHALL leave all state unchanged; the upstream block holds its frame.
REQ-017 out_valid SHALL be high iff count > 0; out_real/out_imag SHALL equal B[rd_sel][idx]; out_index SHALL equal idx.
REQ-018 Output transfer SHALL occur when out_valid && out_ready: idx increments; at idx == 7, idx wraps to 0, rd_sel toggles and the frame is released.
REQ-019 out_real, out_imag, out_index and out_last SHALL stay stable while out_valid is high and out_ready is low.
REQ-020 count SHALL increment on input transfer alone, decrement on a frame release alone, and stay unchanged when both occur in the same cycle.
REQ-021 Latency SHALL be: a frame captured at edge N gives out_valid = 1 with bin 0 during the cycle after edge N when count was 0.
REQ-022 Sustained throughput SHALL be one bin per cycle with out_ready held high; frames stream back-to-back with no idle cycle between bin 7 and the next bin 0.
REQ-023 Data SHALL pass unmodified: no scaling, rounding or saturation, and bit-exact WIDTH in and out.
REQ-024 Frames SHALL be emitted in capture order; no frame is dropped or duplicated.

Reset
REQ-025 While rst is high at a clock edge: count, wr_sel, rd_sel and idx SHALL be set to 0, and all buffer contents SHALL be cleared to 0.
REQ-026 Resulting output values SHALL be: out_valid = 0, out_last = 0, out_index = 0, out_real = out_imag = 0, and in_ready = 0 while rst is asserted.
REQ-027 Reset asserted mid-frame SHALL discard all buffered and partially emitted frames; after rst deasserts the first captured frame starts at bin 0.

Verification
REQ-028 Single frame: capture bins k with real = k+1, imag = -(k+1), out_ready = 1 -> 8 consecutive bins, out_index 0..7, values exact, out_last only on bin 7, then out_valid = 0.
REQ-029 Backpressure: out_ready = 0 for 5 cycles at bin 3 -> out_index = 3 and its data held stable for all 5 cycles, then bins 4..7 follow.
REQ-030 Full buffer: present 3 frames back-to-back with out_ready = 0 -> first two captured, in_ready = 0 after the second, third frame held; releasing out_ready yields frames in order 1, 2, 3.
REQ-031 Simultaneous events: new frame arrives in the same cycle bin 7 is accepted with count = 1 -> count stays 1 and the next cycle shows bin 0 of the new frame.
REQ-032 Reset mid-stream: assert rst at bin 5 of a frame with a second frame queued -> next cycle out_valid = 0, in_ready = 0; after deassert in_ready = 1 and no old data is emitted.
REQ-033 Extremes: bins set to -2^(WIDTH-1) and 2^(WIDTH-1)-1 -> output bit-exact with no sign change.

Source files
------------

// File: rtl/fft_out_serializer.sv
// Ping-pong frame buffer that takes one parallel 8-bin complex FFT frame per
// transfer and streams it out one bin per cycle over a valid/ready interface.
module fft_out_serializer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in_0_real,
    input  logic signed [WIDTH-1:0] x_in_0_imag,
    input  logic signed [WIDTH-1:0] x_in_1_real,
    input  logic signed [WIDTH-1:0] x_in_1_imag,
    input  logic signed [WIDTH-1:0] x_in_2_real,
    input  logic signed [WIDTH-1:0] x_in_2_imag,
    input  logic signed [WIDTH-1:0] x_in_3_real,
    input  logic signed [WIDTH-1:0] x_in_3_imag,
    input  logic signed [WIDTH-1:0] x_in_4_real,
    input  logic signed [WIDTH-1:0] x_in_4_imag,
    input  logic signed [WIDTH-1:0] x_in_5_real,
    input  logic signed [WIDTH-1:0] x_in_5_imag,
    input  logic signed [WIDTH-1:0] x_in_6_real,
    input  logic signed [WIDTH-1:0] x_in_6_imag,
    input  logic signed [WIDTH-1:0] x_in_7_real,
    input  logic signed [WIDTH-1:0] x_in_7_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_real,
    output logic signed [WIDTH-1:0] out_imag,
    output logic [2:0]              out_index,
    output logic                    out_last
);

    localparam int unsigned BINS  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 2;

    logic signed [WIDTH-1:0] in_re [BINS];
    logic signed [WIDTH-1:0] in_im [BINS];

    logic signed [WIDTH-1:0] buf_re_q [FRAMES][BINS];
    logic signed [WIDTH-1:0] buf_im_q [FRAMES][BINS];

    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic in_fire;
    logic out_fire;
    logic frame_release;

    // Gather the parallel input ports into indexable arrays.
    assign in_re[0] = x_in_0_real;
    assign in_im[0] = x_in_0_imag;
    assign in_re[1] = x_in_1_real;
    assign in_im[1] = x_in_1_imag;
    assign in_re[2] = x_in_2_real;
    assign in_im[2] = x_in_2_imag;
    assign in_re[3] = x_in_3_real;
    assign in_im[3] = x_in_3_imag;
    assign in_re[4] = x_in_4_real;
    assign in_im[4] = x_in_4_imag;
    assign in_re[5] = x_in_5_real;
    assign in_im[5] = x_in_5_imag;
    assign in_re[6] = x_in_6_real;
    assign in_im[6] = x_in_6_imag;
    assign in_re[7] = x_in_7_real;
    assign in_im[7] = x_in_7_imag;

    // Handshake status depends on registered state only; no same-cycle drain bypass.
    assign in_ready      = !rst && (count_q < CNT_W'(FRAMES));
    assign out_valid     = (count_q != '0);
    assign in_fire       = in_valid && in_ready;
    assign out_fire      = out_valid && out_ready;
    assign frame_release = out_fire && (idx_q == IDX_W'(BINS - 1));

    assign out_real  = buf_re_q[rd_sel_q][idx_q];
    assign out_imag  = buf_im_q[rd_sel_q][idx_q];
    assign out_index = idx_q;
    assign out_last  = out_valid && (idx_q == IDX_W'(BINS - 1));

    // Next-state for the pointer/occupancy registers.
    always_comb begin
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        count_d  = count_q;
        idx_d    = idx_q;

        if (in_fire) begin
            wr_sel_d = !wr_sel_q;
        end
        if (out_fire) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if (frame_release) begin
            rd_sel_d = !rd_sel_q;
        end
        case ({in_fire, frame_release})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            count_q  <= '0;
            idx_q    <= '0;
            for (int f = 0; f < int'(FRAMES); f++) begin
                for (int k = 0; k < int'(BINS); k++) begin
                    buf_re_q[f][k] <= '0;
                    buf_im_q[f][k] <= '0;
                end
            end
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            if (in_fire) begin
                for (int k = 0; k < int'(BINS); k++) begin
                    buf_re_q[wr_sel_q][k] <= in_re[k];
                    buf_im_q[wr_sel_q][k] <= in_im[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed self-checking bench for fft_out_serializer: single frame, backpressure,
// full buffer, simultaneous capture/release, mid-stream reset and extreme values.
module tb_fft_out_serializer;

    localparam int unsigned WIDTH = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] xr [8];
    logic signed [WIDTH-1:0] xi [8];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_real;
    logic signed [WIDTH-1:0] out_imag;
    logic [2:0]              out_index;
    logic                    out_last;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fft_out_serializer #(.WIDTH(WIDTH), .FRAMES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in_0_real(xr[0]), .x_in_0_imag(xi[0]),
        .x_in_1_real(xr[1]), .x_in_1_imag(xi[1]),
        .x_in_2_real(xr[2]), .x_in_2_imag(xi[2]),
        .x_in_3_real(xr[3]), .x_in_3_imag(xi[3]),
        .x_in_4_real(xr[4]), .x_in_4_imag(xi[4]),
        .x_in_5_real(xr[5]), .x_in_5_imag(xi[5]),
        .x_in_6_real(xr[6]), .x_in_6_imag(xi[6]),
        .x_in_7_real(xr[7]), .x_in_7_imag(xi[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame pattern: bin k has real = base+k, imag = -(base+k).
    task automatic drive_frame(input int base);
        for (int k = 0; k < 8; k++) begin
            xr[k] = 16'(base + k);
            xi[k] = 16'(-(base + k));
        end
    endtask

    task automatic expect_bin(input string tag, input int k, input int er, input int ei);
        check({tag, ".valid"}, int'(out_valid), 1);
        check({tag, ".index"}, int'(out_index), k);
        check({tag, ".real"},  int'(out_real), er);
        check({tag, ".imag"},  int'(out_imag), ei);
        check({tag, ".last"},  int'(out_last), (k == 7) ? 1 : 0);
    endtask

    task automatic stream_frame(input string tag, input int base);
        for (int k = 0; k < 8; k++) begin
            expect_bin(tag, k, base + k, -(base + k));
            tick();
        end
    endtask

    int exp_base [3];
    bit captured;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_frame(0);

        // Reset state
        tick();
        tick();
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.out_last",  int'(out_last), 0);
        check("rst.out_index", int'(out_index), 0);
        check("rst.out_real",  int'(out_real), 0);
        check("rst.out_imag",  int'(out_imag), 0);
        check("rst.in_ready",  int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", int'(in_ready), 1);

        // Single frame, out_ready high: bin 0 in the cycle after capture
        drive_frame(1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        stream_frame("single", 1);
        check("single.done_valid", int'(out_valid), 0);

        // Backpressure at bin 3 for 5 cycles
        drive_frame(20);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_bin("bp", k, 20 + k, -(20 + k));
            tick();
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            expect_bin("bp.hold", 3, 23, -23);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 3; k < 8; k++) begin
            expect_bin("bp", k, 20 + k, -(20 + k));
            tick();
        end
        check("bp.done_valid", int'(out_valid), 0);

        // Full buffer: three frames offered back-to-back with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_frame(40);
        tick();
        drive_frame(50);
        tick();
        check("full.in_ready", int'(in_ready), 0);
        drive_frame(60);
        tick();
        tick();
        check("full.in_ready_held", int'(in_ready), 0);
        expect_bin("full.head", 0, 40, -40);
        out_ready = 1'b1;
        exp_base[0] = 40;
        exp_base[1] = 50;
        exp_base[2] = 60;
        captured = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) begin
                expect_bin("full.drain", k, exp_base[f] + k, -(exp_base[f] + k));
                if (in_valid && in_ready) captured = 1'b1;
                tick();
                if (captured) in_valid = 1'b0;
            end
        end
        check("full.third_captured", int'(captured), 1);
        check("full.done_valid", int'(out_valid), 0);

        // New frame captured in the same cycle bin 7 is accepted with one frame held
        drive_frame(70);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            expect_bin("simul", k, 70 + k, -(70 + k));
            tick();
        end
        expect_bin("simul", 7, 77, -77);
        drive_frame(80);
        in_valid = 1'b1;
        check("simul.in_ready_at_bin7", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("simul.in_ready_after", int'(in_ready), 1);
        stream_frame("simul.next", 80);
        check("simul.done_valid", int'(out_valid), 0);

        // Reset at bin 5 with a second frame queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_frame(90);
        tick();
        drive_frame(100);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_bin("mrst", k, 90 + k, -(90 + k));
            tick();
        end
        expect_bin("mrst", 5, 95, -95);
        rst = 1'b1;
        #1;
        check("mrst.in_ready_during", int'(in_ready), 0);
        tick();
        check("mrst.out_valid", int'(out_valid), 0);
        check("mrst.in_ready",  int'(in_ready), 0);
        check("mrst.out_index", int'(out_index), 0);
        check("mrst.out_real",  int'(out_real), 0);
        rst = 1'b0;
        #1;
        check("mrst.in_ready_release", int'(in_ready), 1);
        for (int c = 0; c < 3; c++) begin
            check("mrst.no_old_data", int'(out_valid), 0);
            tick();
        end
        drive_frame(110);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        stream_frame("mrst.fresh", 110);
        check("mrst.done_valid", int'(out_valid), 0);

        // Extreme values pass through bit-exact
        for (int k = 0; k < 8; k++) begin
            xr[k] = (k % 2 == 0) ? 16'sh8000 : 16'sh7FFF;
            xi[k] = (k % 2 == 0) ? 16'sh7FFF : 16'sh8000;
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) expect_bin("ext", k, -32768, 32767);
            else            expect_bin("ext", k, 32767, -32768);
            tick();
        end
        check("ext.done_valid", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
